// File: rtl/nanoV_mem_pkg.sv
// nanoV serial memory controller shared definitions.
// FSM states, SPI RAM opcodes, len encodings, data-length helper.
package nanoV_mem_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_CMD,
      ST_ADDR,
      ST_DATA,
      ST_END
   } state_t;

   localparam logic [7:0] CMD_READ  = 8'h03;
   localparam logic [7:0] CMD_WRITE = 8'h02;

   localparam logic [1:0] LEN_BYTE = 2'd0;
   localparam logic [1:0] LEN_HALF = 2'd1;
   localparam logic [1:0] LEN_WORD = 2'd2;

   // Index of the last data-phase bit; len=3 behaves as a word.
   function automatic logic [5:0] last_bit(input logic [1:0] l);
      case (l)
         LEN_BYTE: last_bit = 6'd7;
         LEN_HALF: last_bit = 6'd15;
         LEN_WORD: last_bit = 6'd31;
         default:  last_bit = 6'd31;
      endcase
   endfunction

endpackage

// File: rtl/nanoV_spi_phy.sv
// SPI mode-0 bit timing: two clk cycles per bit (low, then high phase).
// Ports: clk, rstn, en (bit slot active) -> spi_clk, rise (low phase ends), sample (high phase ends).
module nanoV_spi_phy (
   input  logic clk,
   input  logic rstn,
   input  logic en,
   output logic spi_clk,
   output logic rise,
   output logic sample
);

   logic phase;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn)
         phase <= 1'b0;
      else if (!en)
         phase <= 1'b0;
      else
         phase <= ~phase;
   end

   assign spi_clk = phase;
   assign rise    = en & ~phase;
   assign sample  = en & phase;

endmodule

// File: rtl/nanov_mem_spi.sv
// nanoV load/store to SPI RAM bridge (sequential mode, CMD+ADDR+DATA).
// Ports: start/is_write/addr/len/wr_data request; busy/done/rd_data/data_in/shift_data_out to core; spi_* to RAM.
module nanov_mem_spi
   import nanoV_mem_pkg::*;
#(
   parameter int ADDR_BITS = 24
) (
   input  logic                 clk,
   input  logic                 rstn,
   input  logic                 start,
   input  logic                 is_write,
   input  logic [ADDR_BITS-1:0] addr,
   input  logic [1:0]           len,
   input  logic [31:0]          wr_data,
   output logic                 busy,
   output logic                 done,
   output logic [31:0]          rd_data,
   output logic                 data_in,
   output logic                 shift_data_out,
   output logic                 spi_cs_n,
   output logic                 spi_clk,
   output logic                 spi_mosi,
   input  logic                 spi_miso
);

   state_t               state;
   logic [5:0]           cnt;
   logic [5:0]           dlast;
   logic [31:0]          sr;
   logic [31:0]          wr_q;
   logic [ADDR_BITS-1:0] addr_q;
   logic                 is_wr;

   logic [7:0]  cmd_byte;
   logic [31:0] a32;
   logic [31:0] swp;
   logic        en;
   logic        rise;
   logic        sample;

   assign cmd_byte = is_write ? CMD_WRITE : CMD_READ;
   // Address left-aligned so its MSB leaves first.
   assign a32 = 32'(addr_q) << (32 - ADDR_BITS);
   // Byte 0 first on the wire, each byte MSB first.
   assign swp = {wr_q[7:0], wr_q[15:8], wr_q[23:16], wr_q[31:24]};
   assign en  = (state == ST_CMD) || (state == ST_ADDR) ||
                (state == ST_DATA);

   nanoV_spi_phy u_phy (
      .clk     (clk),
      .rstn    (rstn),
      .en      (en),
      .spi_clk (spi_clk),
      .rise    (rise),
      .sample  (sample)
   );

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state          <= ST_IDLE;
         busy           <= 1'b0;
         done           <= 1'b0;
         rd_data        <= '0;
         data_in        <= 1'b0;
         shift_data_out <= 1'b0;
         spi_cs_n       <= 1'b1;
         spi_mosi       <= 1'b0;
         cnt            <= '0;
         dlast          <= '0;
         sr             <= '0;
         wr_q           <= '0;
         addr_q         <= '0;
         is_wr          <= 1'b0;
      end else begin
         done           <= 1'b0;
         data_in        <= 1'b0;
         shift_data_out <= 1'b0;
         unique case (state)
            ST_IDLE: begin
               if (start) begin
                  state    <= ST_CMD;
                  busy     <= 1'b1;
                  spi_cs_n <= 1'b0;
                  rd_data  <= '0;
                  wr_q     <= wr_data;
                  addr_q   <= addr;
                  is_wr    <= is_write;
                  dlast    <= last_bit(len);
                  cnt      <= '0;
                  spi_mosi <= cmd_byte[7];
                  sr       <= {cmd_byte[6:0], 25'd0};
               end
            end
            ST_CMD: begin
               if (sample) begin
                  if (cnt == 6'd7) begin
                     state    <= ST_ADDR;
                     cnt      <= '0;
                     spi_mosi <= a32[31];
                     sr       <= {a32[30:0], 1'b0};
                  end else begin
                     cnt      <= cnt + 6'd1;
                     spi_mosi <= sr[31];
                     sr       <= {sr[30:0], 1'b0};
                  end
               end
            end
            ST_ADDR: begin
               if (sample) begin
                  if (cnt == 6'(ADDR_BITS - 1)) begin
                     state    <= ST_DATA;
                     cnt      <= '0;
                     spi_mosi <= is_wr & swp[31];
                     sr       <= {swp[30:0], 1'b0};
                  end else begin
                     cnt      <= cnt + 6'd1;
                     spi_mosi <= sr[31];
                     sr       <= {sr[30:0], 1'b0};
                  end
               end
            end
            ST_DATA: begin
               if (rise && is_wr)
                  shift_data_out <= 1'b1;
               if (sample) begin
                  if (!is_wr) begin
                     // bit j of byte k lands at rd_data[8k+7-j]
                     rd_data[{cnt[4:3], ~cnt[2:0]}] <= spi_miso;
                     data_in        <= spi_miso;
                     shift_data_out <= 1'b1;
                  end
                  if (cnt == dlast) begin
                     state    <= ST_END;
                     cnt      <= '0;
                     spi_cs_n <= 1'b1;
                     spi_mosi <= 1'b0;
                     done     <= 1'b1;
                  end else begin
                     cnt      <= cnt + 6'd1;
                     spi_mosi <= is_wr & sr[31];
                     sr       <= {sr[30:0], 1'b0};
                  end
               end
            end
            ST_END: begin
               state <= ST_IDLE;
               busy  <= 1'b0;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_nanov_mem_spi.sv
// Randomised + directed bench for nanov_mem_spi with a timeline model
// and an SPI RAM device model.
module tb_nanov_mem_spi;

   localparam int AB = 24;

   logic          clk = 1'b0;
   logic          rstn = 1'b0;
   logic          start;
   logic          is_write;
   logic [AB-1:0] addr;
   logic [1:0]    len;
   logic [31:0]   wr_data;
   logic          busy;
   logic          done;
   logic [31:0]   rd_data;
   logic          data_in;
   logic          shift_data_out;
   logic          spi_cs_n;
   logic          spi_clk;
   logic          spi_mosi;
   logic          spi_miso = 1'b0;

   always #5 clk = ~clk;

   nanov_mem_spi #(.ADDR_BITS(AB)) dut (
      .clk            (clk),
      .rstn           (rstn),
      .start          (start),
      .is_write       (is_write),
      .addr           (addr),
      .len            (len),
      .wr_data        (wr_data),
      .busy           (busy),
      .done           (done),
      .rd_data        (rd_data),
      .data_in        (data_in),
      .shift_data_out (shift_data_out),
      .spi_cs_n       (spi_cs_n),
      .spi_clk        (spi_clk),
      .spi_mosi       (spi_mosi),
      .spi_miso       (spi_miso)
   );

   int tests = 0;
   int fails = 0;

   task automatic chk(input string nm, input logic [63:0] act,
                      input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         if (fails <= 40)
            $display("FAIL %s: got %0h, want %0h (t=%0t)",
                     nm, act, exp, $time);
      end
   endtask

   function automatic logic rbit(input logic [31:0] rb, input int j);
      return rb[8 * (j / 8) + 7 - (j % 8)];
   endfunction

   // ---------------- SPI RAM device model ----------------
   logic [31:0] dev_rb = '0;
   logic [63:0] dev_bits = '0;
   int          dk = 0;
   logic        p_cs = 1'b1;
   logic        p_sck = 1'b0;

   function automatic logic dev_out(input int k);
      if (k >= 8 + AB && k < 8 + AB + 32)
         return rbit(dev_rb, k - (8 + AB));
      return 1'($urandom_range(0, 1));
   endfunction

   always @(posedge clk) begin
      #1;
      if (p_cs && !spi_cs_n) begin
         dk = 0;
         dev_bits = '0;
         spi_miso = dev_out(0);
      end else if (!spi_cs_n && p_sck && !spi_clk) begin
         dk++;
         spi_miso = dev_out(dk);
      end
      if (!spi_cs_n && !p_sck && spi_clk)
         dev_bits = {dev_bits[62:0], spi_mosi};
      p_cs = spi_cs_n;
      p_sck = spi_clk;
   end

   // ---------------- transaction timeline model ----------------
   logic        m_act = 1'b0;
   int          m_c = 0;
   int          m_n = 1;
   int          m_B = 0;
   logic        m_w = 1'b0;
   logic [63:0] m_stream = '0;
   logic [31:0] m_rb = '0;
   logic [31:0] m_rd = '0;

   function automatic int nbytes(input logic [1:0] l);
      return (l == 2'd0) ? 1 : (l == 2'd1) ? 2 : 4;
   endfunction

   function automatic logic [31:0] lmask(input int n);
      return (n == 1) ? 32'hFF : (n == 2) ? 32'hFFFF : 32'hFFFF_FFFF;
   endfunction

   always @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         m_act = 1'b0;
         m_rd = '0;
      end else if (m_act) begin
         if (m_c == 2 * m_B + 1) m_act = 1'b0;
         else m_c++;
      end else if (start) begin
         m_act = 1'b1;
         m_c = 1;
         m_w = is_write;
         m_n = nbytes(len);
         m_B = 8 + AB + 8 * m_n;
         m_stream = {(is_write ? 8'h02 : 8'h03), addr,
                     wr_data[7:0], wr_data[15:8],
                     wr_data[23:16], wr_data[31:24]};
         m_rb = dev_rb;
         m_rd = is_write ? 32'h0 : (dev_rb & lmask(m_n));
      end
   end

   // ---------------- per-cycle compare ----------------
   int   ci, chi;
   logic e_busy, e_done, e_cs, e_sck, e_mosi, e_sh, e_din;

   always @(negedge clk) begin
      if (rstn) begin
         e_busy = 1'b1; e_done = 1'b0; e_cs = 1'b0; e_sck = 1'b0;
         e_mosi = 1'b0; e_sh = 1'b0; e_din = 1'b0;
         if (!m_act) begin
            e_busy = 1'b0;
            e_cs = 1'b1;
            chk("idle_rd", rd_data, m_rd);
         end else if (m_c <= 2 * m_B) begin
            ci = (m_c - 1) / 2;
            chi = (m_c - 1) % 2;
            e_sck = (chi == 1);
            if (ci < 8 + AB || m_w) e_mosi = m_stream[63 - ci];
            if (m_w) begin
               e_sh = (chi == 1) && (ci >= 8 + AB);
            end else begin
               e_sh = (chi == 0) && (ci >= 8 + AB + 1);
               if (e_sh) e_din = rbit(m_rb, ci - 1 - (8 + AB));
            end
         end else begin
            e_done = 1'b1;
            e_cs = 1'b1;
            e_sh = !m_w;
            if (!m_w) e_din = rbit(m_rb, 8 * m_n - 1);
            chk("end_rd", rd_data, m_rd);
         end
         chk("busy", busy, e_busy);
         chk("done", done, e_done);
         chk("cs_n", spi_cs_n, e_cs);
         chk("spi_clk", spi_clk, e_sck);
         chk("mosi", spi_mosi, e_mosi);
         chk("shift", shift_data_out, e_sh);
         chk("data_in", data_in, e_din);
      end
   end

   // ---------------- stimulus ----------------
   task automatic txn(input logic w, input logic [AB-1:0] a,
                      input logic [1:0] l, input logic [31:0] d,
                      input logic [31:0] rb, output int lat,
                      output int nst, output logic [31:0] dins,
                      output logic [31:0] rdv);
      is_write = w; addr = a; len = l; wr_data = d; dev_rb = rb;
      start = 1'b1;
      lat = 0; nst = 0; dins = '0; rdv = '0;
      @(negedge clk);
      start = 1'b0;
      chk("accept_busy", busy, 1'b1);
      for (int c = 1; c <= 300; c++) begin
         if (c > 1) @(negedge clk);
         if (shift_data_out) begin
            nst++;
            dins = {dins[30:0], data_in};
         end
         if (done) begin
            lat = c;
            rdv = rd_data;
            break;
         end
      end
      @(negedge clk);
   endtask

   int          lat, nst, ndone, dlat, n;
   logic [31:0] dins, rdv, t_d, t_rb;
   logic [AB-1:0] t_a;
   logic        t_w;
   logic [1:0]  t_l;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: bench did not finish");
      $fatal(1);
   end

   initial begin
      start = 1'b0; is_write = 1'b0; addr = '0; len = '0; wr_data = '0;
      repeat (3) @(negedge clk);
      chk("rst_busy", busy, 1'b0);
      chk("rst_done", done, 1'b0);
      chk("rst_rd", rd_data, 32'h0);
      chk("rst_din", data_in, 1'b0);
      chk("rst_shift", shift_data_out, 1'b0);
      chk("rst_cs", spi_cs_n, 1'b1);
      chk("rst_sck", spi_clk, 1'b0);
      chk("rst_mosi", spi_mosi, 1'b0);
      rstn = 1'b1;
      @(negedge clk);

      txn(1'b1, 24'h000104, 2'd2, 32'h12345678, 32'h0,
          lat, nst, dins, rdv);
      chk("ww_lat", lat, 129);
      chk("ww_strobes", nst, 32);
      chk("ww_mosi", dev_bits, 64'h0200010478563412);

      txn(1'b0, 24'h00ABCD, 2'd0, 32'h0, 32'h5A5A5AA5,
          lat, nst, dins, rdv);
      chk("rb_lat", lat, 81);
      chk("rb_rd", rdv, 32'h000000A5);
      chk("rb_din", dins, 32'hA5);
      chk("rb_strobes", nst, 8);
      chk("rb_mosi", dev_bits[39:0], 40'h0300ABCD00);

      txn(1'b0, 24'h123456, 2'd1, 32'h0, 32'hEEEE1234,
          lat, nst, dins, rdv);
      chk("rh_lat", lat, 97);
      chk("rh_rd", rdv, 32'h00001234);

      // word read with stray start pulses at cycles 10 and 50
      is_write = 1'b0; addr = 24'h000200; len = 2'd2;
      dev_rb = 32'hCAFEF00D; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      ndone = 0; dlat = 0;
      for (int c = 1; c <= 200; c++) begin
         if (c > 1) @(negedge clk);
         start = (c == 10) || (c == 50);
         if (done) begin
            ndone++;
            dlat = c;
            rdv = rd_data;
            break;
         end
      end
      start = 1'b0;
      chk("ms_ndone", ndone, 1);
      chk("ms_lat", dlat, 129);
      chk("ms_rd", rdv, 32'hCAFEF00D);
      @(negedge clk);

      // start in the first IDLE cycle after END
      txn(1'b1, 24'h000010, 2'd0, 32'h000000C3, 32'h0,
          lat, nst, dins, rdv);
      chk("b2b_lat", lat, 81);

      // async reset during ADDR
      is_write = 1'b0; addr = 24'h0F0F0F; len = 2'd2;
      dev_rb = $urandom; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (29) @(negedge clk);
      chk("mr_pre_busy", busy, 1'b1);
      rstn = 1'b0;
      #1;
      chk("mr_cs", spi_cs_n, 1'b1);
      chk("mr_busy", busy, 1'b0);
      chk("mr_rd", rd_data, 32'h0);
      chk("mr_sck", spi_clk, 1'b0);
      chk("mr_mosi", spi_mosi, 1'b0);
      chk("mr_done", done, 1'b0);
      @(negedge clk);
      chk("mr_done2", done, 1'b0);
      rstn = 1'b1;
      @(negedge clk);

      txn(1'b1, 24'h000777, 2'd0, 32'h0000005C, 32'h0,
          lat, nst, dins, rdv);
      chk("pr_lat", lat, 81);
      chk("pr_mosi", dev_bits[7:0], 8'h5C);

      txn(1'b1, 24'h000020, 2'd3, 32'hDEADBEEF, 32'h0,
          lat, nst, dins, rdv);
      chk("l3_lat", lat, 129);
      chk("l3_strobes", nst, 32);
      chk("l3_mosi", dev_bits[31:0], 32'hEFBEADDE);

      for (int k = 0; k < 24; k++) begin
         t_w = 1'($urandom_range(0, 1));
         t_a = 24'($urandom);
         t_l = 2'($urandom_range(0, 3));
         t_d = $urandom;
         t_rb = $urandom;
         n = nbytes(t_l);
         txn(t_w, t_a, t_l, t_d, t_rb, lat, nst, dins, rdv);
         chk("rnd_lat", lat, 2 * (8 + AB + 8 * n) + 1);
         chk("rnd_strobes", nst, 8 * n);
         chk("rnd_rd", rdv, t_w ? 32'h0 : (t_rb & lmask(n)));
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
